// File: rtl/dsp_seq_pkg.sv
// Shared opmode constants, tag encoding and FSM states for the DSP48A1 MAC sequencer.
package dsp_seq_pkg;

    localparam logic [7:0] OPM_CLR  = 8'h01;  // Z=0, X=M
    localparam logic [7:0] OPM_ACC  = 8'h09;  // Z=P, X=M
    localparam logic [7:0] OPM_HOLD = 8'h08;  // Z=P, X=0
    localparam logic [7:0] OPM_IDLE = 8'h00;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_BUBBLE,
        TAG_FIRST,
        TAG_ACC
    } tag_kind_e;

    typedef struct packed {
        tag_kind_e kind;
        logic      last;
    } tag_t;

    localparam tag_t TAG_IDLE = '{kind: TAG_NONE, last: 1'b0};

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    function automatic logic [7:0] tag_opmode(tag_kind_e kind);
        logic [7:0] opm;
        unique case (kind)
            TAG_FIRST:  opm = OPM_CLR;
            TAG_ACC:    opm = OPM_ACC;
            TAG_BUBBLE: opm = OPM_HOLD;
            TAG_NONE:   opm = OPM_IDLE;
            default:    opm = OPM_IDLE;
        endcase
        return opm;
    endfunction

endpackage

// File: rtl/dsp_seq_tagpipe.sv
// Shift register carrying per-cycle term tags alongside the slice pipeline.
module dsp_seq_tagpipe
    import dsp_seq_pkg::*;
#(
    parameter int unsigned Depth = 3,
    parameter int unsigned OpTap = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  tag_t      tag_in,
    output tag_kind_e op_kind,
    output tag_t      tag_p
);

    // Stage 0 lines up with the operands on dsp_a/dsp_b.
    tag_t pipe_q [Depth+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= int'(Depth); i++) begin
                pipe_q[i] <= TAG_IDLE;
            end
        end else begin
            pipe_q[0] <= tag_in;
            for (int i = 1; i <= int'(Depth); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign op_kind = pipe_q[OpTap].kind;
    assign tag_p   = pipe_q[Depth];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Dot-product sequencer feeding one DSP48A1 slice from a valid/ready operand stream.
// Define MAC_OVF_EN to add the sticky m_ovf carry-out flag.
module dsp_mac_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int unsigned P_LAT   = 3,
    parameter int unsigned OP_DLY  = 1,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [17:0]        s_a,
    input  logic [17:0]        s_b,
    input  logic               s_last,
    output logic [17:0]        dsp_a,
    output logic [17:0]        dsp_b,
    output logic [17:0]        dsp_d,
    output logic [7:0]         dsp_opmode,
    output logic               dsp_carryin,
    input  logic [47:0]        dsp_p,
    input  logic               dsp_carryout,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [47:0]        m_result,
`ifdef MAC_OVF_EN
    output logic               m_ovf,
`endif
    output logic [COUNT_W-1:0] m_count
);

    state_e             state_q, state_d;
    tag_t               tag_in, tag_p;
    tag_kind_e          op_kind;
    logic               alive_q;
    logic               accept, load, capture, last_done;
    logic [17:0]        a_q, b_q;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [47:0]        result_q;

    dsp_seq_tagpipe #(
        .Depth (P_LAT),
        .OpTap (OP_DLY)
    ) u_tagpipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .op_kind (op_kind),
        .tag_p   (tag_p)
    );

    // alive_q keeps s_ready low until the first edge after reset.
    assign s_ready   = alive_q && (state_q == StIdle || state_q == StRun);
    assign accept    = s_valid && s_ready;
    assign last_done = tag_p.last && (tag_p.kind == TAG_FIRST || tag_p.kind == TAG_ACC);

    always_comb begin
        state_d = state_q;
        tag_in  = TAG_IDLE;
        load    = 1'b0;
        capture = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    tag_in  = '{kind: TAG_FIRST, last: s_last};
                    load    = 1'b1;
                    cnt_d   = COUNT_W'(1);
                    state_d = s_last ? StDrain : StRun;
                end
            end
            StRun: begin
                if (accept) begin
                    tag_in = '{kind: TAG_ACC, last: s_last};
                    load   = 1'b1;
                    cnt_d  = cnt_q + COUNT_W'(1);
                    if (s_last) begin
                        state_d = StDrain;
                    end
                end else begin
                    tag_in = '{kind: TAG_BUBBLE, last: 1'b0};
                end
            end
            StDrain: begin
                if (last_done) begin
                    capture = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (m_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            alive_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
            cnt_q   <= cnt_d;
            if (load) begin
                a_q <= s_a;
                b_q <= s_b;
            end
            if (capture) begin
                result_q <= dsp_p;
            end
        end
    end

`ifdef MAC_OVF_EN
    logic ovf_q;

    // Carry is only meaningful on cycles where P holds an accumulated term.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (tag_p.kind == TAG_FIRST) begin
            ovf_q <= 1'b0;
        end else if (tag_p.kind == TAG_ACC && dsp_carryout) begin
            ovf_q <= 1'b1;
        end
    end

    assign m_ovf = ovf_q;
`else
    logic unused_carryout;
    assign unused_carryout = dsp_carryout;
`endif

    assign dsp_a       = a_q;
    assign dsp_b       = b_q;
    assign dsp_d       = '0;
    assign dsp_carryin = 1'b0;
    assign dsp_opmode  = tag_opmode(op_kind);
    assign m_valid     = (state_q == StDone);
    assign m_result    = result_q;
    assign m_count     = cnt_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Scoreboard bench for dsp_mac_sequencer with a behavioural DSP48A1 slice model.
module tb_dsp_mac_sequencer;

    localparam int unsigned P_LAT   = 3;
    localparam int unsigned COUNT_W = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               s_valid, s_ready, s_last;
    logic [17:0]        s_a, s_b;
    logic [17:0]        dsp_a, dsp_b, dsp_d;
    logic [7:0]         dsp_opmode;
    logic               dsp_carryin;
    logic [47:0]        dsp_p;
    logic               dsp_carryout;
    logic               m_valid, m_ready;
    logic [47:0]        m_result;
    logic [COUNT_W-1:0] m_count;
`ifdef MAC_OVF_EN
    logic               m_ovf;
`endif

    always #5 clk = ~clk;

    dsp_mac_sequencer #(
        .P_LAT   (P_LAT),
        .OP_DLY  (1),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_a          (s_a),
        .s_b          (s_b),
        .s_last       (s_last),
        .dsp_a        (dsp_a),
        .dsp_b        (dsp_b),
        .dsp_d        (dsp_d),
        .dsp_opmode   (dsp_opmode),
        .dsp_carryin  (dsp_carryin),
        .dsp_p        (dsp_p),
        .dsp_carryout (dsp_carryout),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_result     (m_result),
`ifdef MAC_OVF_EN
        .m_ovf        (m_ovf),
`endif
        .m_count      (m_count)
    );

    // Slice model: A1/B1 -> M -> P, opmode registered once; unsigned 48-bit post-adder.
    logic [17:0] a1_q = '0, b1_q = '0;
    logic [35:0] m_q = '0;
    logic [7:0]  opm_q = '0;
    logic [47:0] p_q = '0;
    logic        co_q = 1'b0;
    logic [47:0] x_mux, z_mux;

    always_comb begin
        x_mux = (opm_q[1:0] == 2'b01) ? {12'b0, m_q} : 48'd0;
        z_mux = (opm_q[3:2] == 2'b10) ? p_q : 48'd0;
    end

    always @(posedge clk) begin
        a1_q           <= dsp_a;
        b1_q           <= dsp_b;
        m_q            <= 36'(a1_q) * 36'(b1_q);
        opm_q          <= dsp_opmode;
        {co_q, p_q}    <= {1'b0, z_mux} + {1'b0, x_mux};
    end

    assign dsp_p        = p_q;
    assign dsp_carryout = co_q;

    typedef struct {
        logic [47:0]        result;
        logic [COUNT_W-1:0] count;
        logic               ovf;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_opm[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         t_last = 0;
    logic       opm_en = 1'b1;
    logic       prev_valid = 1'b0;
    logic [7:0] opm_front;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic expect_result(input logic [47:0] r, input logic [COUNT_W-1:0] c,
                                 input logic o);
        exp_t e;
        e.result = r;
        e.count  = c;
        e.ovf    = o;
        exp_q.push_back(e);
    endtask

    task automatic push_opm(input logic [7:0] opm, input int n);
        for (int i = 0; i < n; i++) exp_opm.push_back(opm);
    endtask

    // Result monitor: checks every cycle m_valid is high (stability), pops on handshake.
    always @(negedge clk) begin
        if (!rst && m_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected m_valid", 64'(m_valid), 64'(0));
            end else begin
                check("m_result", 64'(m_result), 64'(exp_q[0].result));
                check("m_count", 64'(m_count), 64'(exp_q[0].count));
`ifdef MAC_OVF_EN
                check("m_ovf", 64'(m_ovf), 64'(exp_q[0].ovf));
`endif
                if (!prev_valid) check("result latency", 64'(cyc - t_last), 64'(P_LAT + 1));
                if (m_ready) void'(exp_q.pop_front());
            end
        end
        prev_valid = rst ? 1'b0 : m_valid;
    end

    // Opmode monitor: every non-idle opmode must match the next expected one.
    always @(negedge clk) begin
        if (!rst && opm_en && dsp_opmode != 8'h00) begin
            if (exp_opm.size() == 0) begin
                check("unexpected dsp_opmode", 64'(dsp_opmode), 64'(0));
            end else begin
                opm_front = exp_opm.pop_front();
                check("dsp_opmode", 64'(dsp_opmode), 64'(opm_front));
            end
        end
    end

    task automatic send_pair(input logic [17:0] a, input logic [17:0] b, input logic last);
        int n = 0;
        s_valid = 1'b1;
        s_a     = a;
        s_b     = b;
        s_last  = last;
        @(negedge clk);
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            check("s_ready timeout", 64'(s_ready), 64'(1));
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (last) t_last = cyc;
        s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("result timeout", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] big;
        int          n;
        s_valid = 1'b0;
        s_a     = '0;
        s_b     = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("reset s_ready", 64'(s_ready), 64'(0));
        check("reset dsp_a", 64'(dsp_a), 64'(0));
        check("reset dsp_b", 64'(dsp_b), 64'(0));
        check("reset dsp_d", 64'(dsp_d), 64'(0));
        check("reset dsp_opmode", 64'(dsp_opmode), 64'(0));
        check("reset dsp_carryin", 64'(dsp_carryin), 64'(0));
        check("reset m_valid", 64'(m_valid), 64'(0));
        check("reset m_result", 64'(m_result), 64'(0));
        check("reset m_count", 64'(m_count), 64'(0));
        #2 rst = 1'b0;
        @(negedge clk);
        check("s_ready after reset", 64'(s_ready), 64'(1));
        @(posedge clk);
        #1;

        // Back-to-back three-term product.
        push_opm(8'h01, 1);
        push_opm(8'h09, 2);
        expect_result(48'd68, 16'd3, 1'b0);
        send_pair(18'd2, 18'd3, 1'b0);
        send_pair(18'd4, 18'd5, 1'b0);
        send_pair(18'd6, 18'd7, 1'b1);
        wait_drain();

        // Single pair.
        push_opm(8'h01, 1);
        expect_result(48'd1000000, 16'd1, 1'b0);
        send_pair(18'd1000, 18'd1000, 1'b1);
        wait_drain();

        // Two bubbles between terms.
        push_opm(8'h01, 1);
        push_opm(8'h08, 2);
        push_opm(8'h09, 1);
        expect_result(48'd10, 16'd2, 1'b0);
        send_pair(18'd1, 18'd1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        send_pair(18'd3, 18'd3, 1'b1);
        wait_drain();

        // Back-pressure in DONE, then a new stream queued against the handshake.
        m_ready = 1'b0;
        push_opm(8'h01, 1);
        push_opm(8'h09, 2);
        expect_result(48'd68, 16'd3, 1'b0);
        send_pair(18'd2, 18'd3, 1'b0);
        send_pair(18'd4, 18'd5, 1'b0);
        send_pair(18'd6, 18'd7, 1'b1);
        n = 0;
        while (!m_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("m_valid under back-pressure", 64'(m_valid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("s_ready in DONE", 64'(s_ready), 64'(0));
            check("m_valid held", 64'(m_valid), 64'(1));
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        push_opm(8'h01, 1);
        expect_result(48'd30, 16'd1, 1'b0);
        send_pair(18'd5, 18'd6, 1'b1);
        wait_drain();

        // Reset in the middle of RUN.
        opm_en = 1'b0;
        send_pair(18'd1, 18'd2, 1'b0);
        send_pair(18'd3, 18'd4, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("mid-reset dsp_a", 64'(dsp_a), 64'(0));
        check("mid-reset dsp_b", 64'(dsp_b), 64'(0));
        check("mid-reset dsp_opmode", 64'(dsp_opmode), 64'(0));
        check("mid-reset m_valid", 64'(m_valid), 64'(0));
        check("mid-reset m_result", 64'(m_result), 64'(0));
        check("mid-reset m_count", 64'(m_count), 64'(0));
        check("mid-reset s_ready", 64'(s_ready), 64'(0));
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        opm_en = 1'b1;
        push_opm(8'h01, 1);
        expect_result(48'd25, 16'd1, 1'b0);
        send_pair(18'd5, 18'd5, 1'b1);
        wait_drain();

`ifdef MAC_OVF_EN
        // 4097 maximal unsigned products overflow the 48-bit accumulator.
        big = 64'd4097 * 64'h3FFFF * 64'h3FFFF;
        push_opm(8'h01, 1);
        push_opm(8'h09, 4096);
        expect_result(big[47:0], 16'd4097, 1'b1);
        for (int i = 0; i < 4097; i++) send_pair(18'h3FFFF, 18'h3FFFF, (i == 4096));
        wait_drain();
        push_opm(8'h01, 1);
        expect_result(48'd4, 16'd1, 1'b0);
        send_pair(18'd2, 18'd2, 1'b1);
        wait_drain();
`else
        big = '0;
`endif

        repeat (5) @(negedge clk);
        check("opmode queue drained", 64'(exp_opm.size()), 64'(0));
        check("result queue drained", 64'(exp_q.size()), 64'(big[63:63] & 1'b0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
